// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one registered UART TX byte slot among NREQ byte sources.
// Define TX_ARB_LOCK_EN to keep the grant on one source until its req_last byte is accepted.
module uart_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_en,
    input  logic [NREQ-1:0]    i_req_valid,
    input  logic [NREQ*DW-1:0] i_req_data,
    input  logic [NREQ-1:0]    i_req_last,
    output logic [NREQ-1:0]    o_req_ready,
    output logic [DW-1:0]      o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic [IDW-1:0]     o_grant_id,
    output logic               o_busy
);

    logic [IDW-1:0]  r_ptr;
    logic [DW-1:0]   r_txData;
    logic            r_txValid;
    logic [IDW-1:0]  r_grantId;

    logic [NREQ-1:0] w_cand;
    logic [IDW-1:0]  w_sel;
    logic [IDW-1:0]  w_scanIdx;
    logic            w_found;
    logic            w_slotFree;
    logic            w_capture;
    logic            w_advance;
    logic            w_locked;
    logic [IDW-1:0]  w_selNext;
    logic [DW-1:0]   w_selData;

    assign w_slotFree = !r_txValid || i_tx_ready;
    // Gating with rstn keeps req_ready low while reset is held, not only after the first edge.
    assign w_capture  = rstn && i_en && w_slotFree && w_found;
    assign w_selNext  = (w_sel == IDW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
    assign w_selData  = i_req_data[int'(w_sel)*DW +: DW];

    // Walking the scan backwards lets the first candidate after r_ptr win without a break.
    always_comb begin
        w_sel     = '0;
        w_found   = 1'b0;
        w_scanIdx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_scanIdx = IDW'((int'(r_ptr) + k) % NREQ);
            if (w_cand[w_scanIdx]) begin
                w_sel   = w_scanIdx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (w_capture) begin
            o_req_ready = NREQ'(1) << w_sel;
        end
    end

`ifdef TX_ARB_LOCK_EN
    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } state_e;

    state_e         r_state;
    state_e         w_stateNext;
    logic [IDW-1:0] r_owner;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_OPEN;
            r_owner <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_capture && (r_state == ST_OPEN) && !i_req_last[w_sel]) begin
                r_owner <= w_sel;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_OPEN: begin
                if (w_capture && !i_req_last[w_sel]) begin
                    w_stateNext = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_capture && i_req_last[w_sel]) begin
                    w_stateNext = ST_OPEN;
                end
            end
            default: w_stateNext = ST_OPEN;
        endcase
    end

    // While locked only the owner may win; the pointer moves only when a message ends.
    always_comb begin
        w_locked  = (r_state == ST_LOCKED);
        w_cand    = w_locked ? (i_req_valid & (NREQ'(1) << r_owner)) : i_req_valid;
        w_advance = w_capture && i_req_last[w_sel];
    end
`else
    logic w_unusedLast;

    assign w_unusedLast = ^i_req_last;
    assign w_locked     = 1'b0;
    assign w_cand       = i_req_valid;
    assign w_advance    = w_capture;
`endif

    // The slot refills in the same cycle it drains, giving one byte per clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_txValid <= 1'b0;
            r_txData  <= '0;
            r_grantId <= '0;
            r_ptr     <= '0;
        end else begin
            if (w_capture) begin
                r_txValid <= 1'b1;
                r_txData  <= w_selData;
                r_grantId <= w_sel;
            end else if (i_tx_ready) begin
                r_txValid <= 1'b0;
            end
            if (w_advance) begin
                r_ptr <= w_selNext;
            end
        end
    end

    assign o_tx_data  = r_txData;
    assign o_tx_valid = r_txValid;
    assign o_grant_id = r_grantId;
    assign o_busy     = r_txValid || w_locked;

endmodule
